alu_sequencer: RTL and testbench

- Multi-cycle control FSM that drives the datapath (register file, A/B/C pipeline registers, status register, ALU) to execute one 16-bit instruction per start request.
- It is the initiator side of the ALU interface: it generates ALUop, operand loads and writeback strobes that the ALU and datapath consume.
- It sits between the instruction source (bench or future fetch unit) and the datapath.

---
 rtl/alu_sequencer_pkg.sv | 56 +++++
 rtl/alu_sequencer_instr_decode.sv | 47 ++++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: instruction fields, FSM states,
// writeback-mux codes and the ALUop codes the ALU consumes.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned RIDX_W = 3;

  // opcode[15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op[12:11] within the MOV class
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // op[12:11] within the ALU class
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // ALUop codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // writeback mux select
  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_REG,
    S_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN,
    CLS_ILLEGAL
  } iclass_t;

  function automatic logic [15:0] sign_ext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/alu_sequencer_instr_decode.sv
// Combinational instruction decoder: splits the instruction register into
// register fields, the sign-extended immediate and an instruction class.
module instr_decode
  import alu_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output logic        illegal
);

  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sign_ext8(ir[7:0]);

  // Classify opcode/op pairs; anything not listed is illegal.
  always_comb begin
    iclass = CLS_ILLEGAL;
    case (ir[15:13])
      OPC_MOV: begin
        case (ir[12:11])
          OP_MOV_IMM: iclass = CLS_MOV_IMM;
          OP_MOV_REG: iclass = CLS_MOV_REG;
          default:    iclass = CLS_ILLEGAL;
        endcase
      end
      OPC_ALU: begin
        case (ir[12:11])
          OP_ADD:  iclass = CLS_ADD;
          OP_CMP:  iclass = CLS_CMP;
          OP_AND:  iclass = CLS_AND;
          default: iclass = CLS_MVN;
        endcase
      end
      default: iclass = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == CLS_ILLEGAL);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM: captures one instruction per start request and
// sequences register reads, ALU execution and writeback for the datapath.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W-1:0]            instr,
  output logic                    w,
  output logic                    illegal,
  output logic [$clog2(NREG)-1:0] readnum,
  output logic [$clog2(NREG)-1:0] writenum,
  output logic                    write,
  output logic                    loada,
  output logic                    loadb,
  output logic                    loadc,
  output logic                    loads,
  output logic                    asel,
  output logic                    bsel,
  output logic [1:0]              vsel,
  output logic [1:0]              shift,
  output logic [1:0]              ALUop,
  output logic [W-1:0]            sximm8
);

  state_t      state;
  state_t      state_next;
  logic [15:0] ir;

  iclass_t     iclass;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [1:0]  sh;
  logic        dec_illegal;

  instr_decode u_decode (
    .ir      (ir),
    .iclass  (iclass),
    .rn      (rn),
    .rd      (rd),
    .rm      (rm),
    .sh      (sh),
    .sximm8  (sximm8),
    .illegal (dec_illegal)
  );

  assign shift = sh;
  assign bsel  = 1'b0;

  // State register; reset returns to WAIT from any point in an instruction.
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= state_next;
  end

  // Instruction register: loads only on an accepted start in WAIT.
  always_ff @(posedge clk) begin
    if (reset)                          ir <= '0;
    else if (state == S_WAIT && start)  ir <= instr;
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (start) state_next = S_DECODE;
      S_DECODE: begin
        case (iclass)
          CLS_MOV_IMM:                state_next = S_WR_IMM;
          CLS_MOV_REG, CLS_MVN:       state_next = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:  state_next = S_GET_A;
          default:                    state_next = S_WAIT;
        endcase
      end
      S_GET_A:  state_next = S_GET_B;
      S_GET_B:  state_next = S_EXEC;
      S_EXEC:   state_next = (iclass == CLS_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_next = S_WAIT;
      S_WR_IMM: state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Moore outputs from state and IR; write is also masked by reset so a
  // reset edge arriving during writeback never commits a register.
  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    vsel     = VSEL_C;
    ALUop    = ALU_ADD;
    case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = dec_illegal;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        case (iclass)
          CLS_CMP: ALUop = ALU_SUB;
          CLS_AND: ALUop = ALU_AND;
          CLS_MVN: ALUop = ALU_NOT;
          default: ALUop = ALU_ADD;
        endcase
        asel  = (iclass == CLS_MOV_REG) || (iclass == CLS_MVN);
        loadc = (iclass != CLS_CMP);
        loads = (iclass == CLS_CMP);
      end
      S_WR_REG: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = ~reset;
      end
      S_WR_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM;
        write    = ~reset;
      end
      default: w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: each issued instruction pushes its
// expected per-cycle control vectors into a scoreboard, popped every cycle.
module tb_alu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] instr;
  logic        w;
  logic        illegal;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;

  alu_sequencer #(.NREG(8), .W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .instr    (instr),
    .w        (w),
    .illegal  (illegal),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic        rn_care;
    logic [2:0]  readnum;
    logic        wn_care;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel_care;
    logic        asel;
    logic [1:0]  vsel;
    logic        alu_care;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
  } exp_t;

  localparam int T_WAIT = 0, T_DEC = 1, T_GA = 2, T_GB = 3, T_EX = 4, T_WR = 5, T_WI = 6;
  localparam int K_MOVI = 0, K_MOVR = 1, K_ADD = 2, K_CMP = 3, K_AND = 4, K_MVN = 5, K_ILL = 6;

  exp_t        sb[$];
  logic [15:0] m_ir;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc    = 0;

  function automatic int kind_of(input logic [15:0] i);
    if (i[15:13] == 3'b110 && i[12:11] == 2'b10) return K_MOVI;
    if (i[15:13] == 3'b110 && i[12:11] == 2'b00) return K_MOVR;
    if (i[15:13] == 3'b101) begin
      case (i[12:11])
        2'b00:   return K_ADD;
        2'b01:   return K_CMP;
        2'b10:   return K_AND;
        default: return K_MVN;
      endcase
    end
    return K_ILL;
  endfunction

  function automatic exp_t expect_state(input int st, input logic [15:0] i);
    exp_t e;
    int   k;
    k           = kind_of(i);
    e           = '0;
    e.asel_care = 1'b1;
    e.shift     = i[4:3];
    e.sximm8    = {{8{i[7]}}, i[7:0]};
    case (st)
      T_WAIT: e.w = 1'b1;
      T_DEC:  e.illegal = (k == K_ILL);
      T_GA: begin e.loada = 1'b1; e.rn_care = 1'b1; e.readnum = i[10:8]; end
      T_GB: begin e.loadb = 1'b1; e.rn_care = 1'b1; e.readnum = i[2:0]; end
      T_EX: begin
        e.alu_care  = 1'b1;
        e.aluop     = (k == K_MOVR) ? 2'b00 : i[12:11];
        e.asel_care = (k != K_MVN);
        e.asel      = (k == K_MOVR);
        e.loadc     = (k != K_CMP);
        e.loads     = (k == K_CMP);
      end
      T_WR: begin e.write = 1'b1; e.wn_care = 1'b1; e.writenum = i[7:5]; e.vsel = 2'b00; end
      T_WI: begin e.write = 1'b1; e.wn_care = 1'b1; e.writenum = i[10:8]; e.vsel = 2'b10; end
      default: e.w = 1'b0;
    endcase
    return e;
  endfunction

  task automatic push(input int st);
    sb.push_back(expect_state(st, m_ir));
  endtask

  // Expected cycles after the capturing edge, ending with the return to WAIT.
  task automatic push_seq(input logic [15:0] i);
    int k;
    m_ir = i;
    k    = kind_of(i);
    push(T_DEC);
    case (k)
      K_MOVI:        push(T_WI);
      K_MOVR, K_MVN: begin push(T_GB); push(T_EX); push(T_WR); end
      K_ADD, K_AND:  begin push(T_GA); push(T_GB); push(T_EX); push(T_WR); end
      K_CMP:         begin push(T_GA); push(T_GB); push(T_EX); end
      default:       ;
    endcase
    push(T_WAIT);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL c%0d.scoreboard_empty observed=empty expected=entry", cyc);
    end else begin
      e = sb.pop_front();
      check($sformatf("c%0d.w", cyc),       16'(w),       16'(e.w));
      check($sformatf("c%0d.illegal", cyc), 16'(illegal), 16'(e.illegal));
      check($sformatf("c%0d.write", cyc),   16'(write),   16'(e.write));
      check($sformatf("c%0d.loada", cyc),   16'(loada),   16'(e.loada));
      check($sformatf("c%0d.loadb", cyc),   16'(loadb),   16'(e.loadb));
      check($sformatf("c%0d.loadc", cyc),   16'(loadc),   16'(e.loadc));
      check($sformatf("c%0d.loads", cyc),   16'(loads),   16'(e.loads));
      check($sformatf("c%0d.bsel", cyc),    16'(bsel),    16'(1'b0));
      check($sformatf("c%0d.vsel", cyc),    16'(vsel),    16'(e.vsel));
      check($sformatf("c%0d.shift", cyc),   16'(shift),   16'(e.shift));
      check($sformatf("c%0d.sximm8", cyc),  sximm8,       e.sximm8);
      if (e.rn_care)   check($sformatf("c%0d.readnum", cyc),  16'(readnum),  16'(e.readnum));
      if (e.wn_care)   check($sformatf("c%0d.writenum", cyc), 16'(writenum), 16'(e.writenum));
      if (e.asel_care) check($sformatf("c%0d.asel", cyc),     16'(asel),     16'(e.asel));
      if (e.alu_care)  check($sformatf("c%0d.ALUop", cyc),    16'(ALUop),    16'(e.aluop));
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) cycle();
  endtask

  // Called at a WAIT-cycle negedge: start is seen on the following edge.
  task automatic issue(input logic [15:0] i);
    start = 1'b1;
    instr = i;
    push_seq(i);
    cycle();
    start = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    instr = '0;
    m_ir  = '0;

    push(T_WAIT); push(T_WAIT);
    cycle(); cycle();
    reset = 1'b0;
    push(T_WAIT);
    cycle();

    issue(16'hD2FB);   // MOV R2,#-5
    issue(16'hA168);   // ADD R3,R1,R0 (sh=01)
    issue(16'hA900);   // CMP R1,R0

    // MVN R5,R2 with a second start during GET_B that must be ignored
    start = 1'b1;
    instr = 16'hB8A2;
    push_seq(16'hB8A2);
    cycle();             // DECODE
    start = 1'b0;
    cycle();             // GET_B
    start = 1'b1;
    instr = 16'hD001;
    cycle();             // EXEC
    start = 1'b0;
    drain();

    issue(16'hC0E9);   // MOV R7,R1 (sh=01)
    issue(16'hB453);   // AND R2,R4,R3
    issue(16'hE000);   // illegal opcode
    issue(16'hC800);   // illegal MOV op=01
    issue(16'hD87F);   // illegal ALU-less op=11 in MOV class

    // Reset while in EXEC of an ADD
    start = 1'b1;
    instr = 16'hA168;
    push_seq(16'hA168);
    cycle();             // DECODE
    start = 1'b0;
    cycle(); cycle(); cycle();   // GET_A, GET_B, EXEC
    reset = 1'b1;
    sb.delete();
    m_ir = '0;
    push(T_WAIT); cycle();
    push(T_WAIT); cycle();
    reset = 1'b0;
    push(T_WAIT); cycle();

    // Reset arriving during WR_REG must mask the write strobe
    start = 1'b1;
    instr = 16'hB453;
    push_seq(16'hB453);
    cycle();             // DECODE
    start = 1'b0;
    cycle(); cycle(); cycle(); cycle();   // GET_A, GET_B, EXEC, WR_REG
    reset = 1'b1;
    #1;
    check("rst_edge.write", 16'(write), 16'h0000);
    sb.delete();
    m_ir = '0;
    push(T_WAIT); cycle();
    reset = 1'b0;
    push(T_WAIT); cycle();

    issue(16'hD2FB);   // back-to-back after reset recovery

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
